// File: rtl/bank_host_pkg.sv
// Shared types for the bank host responder: request opcodes, response status codes
// and the request FSM state encoding.
package bank_host_pkg;

    typedef enum logic [1:0] {
        OpPin = 2'd0,
        OpWdr = 2'd1,
        OpDep = 2'd2,
        OpEnd = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        StsOk        = 3'd0,
        StsBadPin    = 3'd1,
        StsLocked    = 3'd2,
        StsNoSession = 3'd3,
        StsInsuff    = 3'd4,
        StsLimit     = 3'd5,
        StsFaceFail  = 3'd6,
        StsOverflow  = 3'd7
    } status_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/bank_host_if.sv
// Request/response bus between the ATM controller (master) and the bank host
// responder (slave), including the lock and session status flags.
interface bank_host_if;
    import bank_host_pkg::*;

    logic       req_valid;
    logic       req_ready;
    op_e        req_op;
    logic [3:0] req_pin;
    logic [3:0] req_amount;
    logic       face_ok;
    logic       rsp_valid;
    logic       rsp_ready;
    status_e    rsp_status;
    logic [3:0] rsp_balance;
    logic       locked;
    logic       session;

    modport master (
        output req_valid, req_op, req_pin, req_amount, face_ok, rsp_ready,
        input  req_ready, rsp_valid, rsp_status, rsp_balance, locked, session
    );

    modport slave (
        input  req_valid, req_op, req_pin, req_amount, face_ok, rsp_ready,
        output req_ready, rsp_valid, rsp_status, rsp_balance, locked, session
    );

endinterface

// File: rtl/bank_host_lock_timer.sv
// Card lock timer: armed by start_i, pulses expire_o in the LOCK_CYCLES-th cycle
// after arming so the lock can be released on that edge.
module bank_host_lock_timer #(
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    output logic expire_o
);
    localparam int unsigned CntW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(LOCK_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (start_i) begin
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == LastCnt) begin
                cnt_d = '0;
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    assign expire_o = run_q && (cnt_q == LastCnt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/bank_host_responder.sv
// Bank host responder: accepts PIN/withdraw/deposit/end requests, one at a time,
// and answers with a status and the resulting balance. Define
// BANK_HOST_LOCK_TIMEOUT_EN to release a card lock after LOCK_CYCLES cycles.
module bank_host_responder
    import bank_host_pkg::*;
#(
    parameter logic [3:0]  PIN_CODE     = 4'd1,
    parameter logic [3:0]  INIT_BALANCE = 4'd14,
    parameter int unsigned FACE_LIMIT   = 10,
    parameter int unsigned MAX_DEPOSIT  = 10,
    parameter int unsigned LOCK_CYCLES  = 16
) (
    input logic        clk,
    input logic        reset,
    bank_host_if.slave bus
);
    state_e     state_q, state_d;
    op_e        op_q, op_d;
    logic [3:0] pin_q, pin_d;
    logic [3:0] amount_q, amount_d;
    logic       face_q, face_d;
    logic [3:0] balance_q, balance_d;
    logic [1:0] attempts_q, attempts_d;
    logic       locked_q, locked_d;
    logic       session_q, session_d;
    status_e    status_q, status_d;
    logic       lock_expire;
    logic [4:0] dep_sum;

    assign dep_sum = {1'b0, balance_q} + {1'b0, amount_q};

`ifdef BANK_HOST_LOCK_TIMEOUT_EN
    bank_host_lock_timer #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock_timer (
        .clk      (clk),
        .reset    (reset),
        .start_i  (locked_d && !locked_q),
        .expire_o (lock_expire)
    );
`else
    assign lock_expire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        pin_d      = pin_q;
        amount_d   = amount_q;
        face_d     = face_q;
        balance_d  = balance_q;
        attempts_d = attempts_q;
        locked_d   = locked_q;
        session_d  = session_q;
        status_d   = status_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    op_d     = bus.req_op;
                    pin_d    = bus.req_pin;
                    amount_d = bus.req_amount;
                    face_d   = bus.face_ok;
                    state_d  = StExec;
                end
            end
            StExec: begin
                state_d = StResp;
                // END is honoured even on a locked card so the controller can eject it.
                if (op_q == OpEnd) begin
                    status_d  = StsOk;
                    session_d = 1'b0;
                end else if (locked_q) begin
                    status_d = StsLocked;
                end else if (op_q == OpPin) begin
                    if (pin_q == PIN_CODE) begin
                        status_d   = StsOk;
                        session_d  = 1'b1;
                        attempts_d = 2'd0;
                    end else if (attempts_q == 2'd2) begin
                        status_d   = StsLocked;
                        locked_d   = 1'b1;
                        session_d  = 1'b0;
                        attempts_d = 2'd0;
                    end else begin
                        status_d   = StsBadPin;
                        attempts_d = attempts_q + 2'd1;
                    end
                end else if (!session_q) begin
                    status_d = StsNoSession;
                end else if (op_q == OpWdr) begin
                    if (32'(amount_q) > FACE_LIMIT && !face_q) begin
                        status_d = StsFaceFail;
                    end else if (amount_q > balance_q) begin
                        status_d = StsInsuff;
                    end else begin
                        status_d  = StsOk;
                        balance_d = balance_q - amount_q;
                    end
                end else begin
                    if (32'(amount_q) > MAX_DEPOSIT) begin
                        status_d = StsLimit;
                    end else if (dep_sum > 5'd15) begin
                        status_d = StsOverflow;
                    end else begin
                        status_d  = StsOk;
                        balance_d = dep_sum[3:0];
                    end
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (lock_expire) begin
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            op_q       <= OpPin;
            pin_q      <= '0;
            amount_q   <= '0;
            face_q     <= 1'b0;
            balance_q  <= INIT_BALANCE;
            attempts_q <= 2'd0;
            locked_q   <= 1'b0;
            session_q  <= 1'b0;
            status_q   <= StsOk;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            pin_q      <= pin_d;
            amount_q   <= amount_d;
            face_q     <= face_d;
            balance_q  <= balance_d;
            attempts_q <= attempts_d;
            locked_q   <= locked_d;
            session_q  <= session_d;
            status_q   <= status_d;
        end
    end

    assign bus.req_ready   = (state_q == StIdle);
    assign bus.rsp_valid   = (state_q == StResp);
    assign bus.rsp_status  = status_q;
    assign bus.rsp_balance = balance_q;
    assign bus.locked      = locked_q;
    assign bus.session     = session_q;

endmodule

// File: tb/tb_bank_host_responder.sv
// Scoreboard bench for bank_host_responder: driver runs directed and random requests
// through a behavioural account model; a negedge monitor checks each response.
module tb_bank_host_responder;
    import bank_host_pkg::*;

    localparam int PinCode   = 1;
    localparam int InitBal   = 14;
    localparam int FaceLimit = 10;
    localparam int MaxDep    = 10;

    typedef struct {
        int status;
        int balance;
        int locked;
        int session;
    } exp_t;

    logic clk;
    logic reset;
    bank_host_if bus ();

    bank_host_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    // Account model
    int m_bal, m_att, m_lock, m_sess;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bal  = InitBal;
        m_att  = 0;
        m_lock = 0;
        m_sess = 0;
    endtask

    task automatic model_exec(input int op, input int pin, input int amt, input int face,
                              output int st);
        if (op == 3) begin
            st     = 0;
            m_sess = 0;
        end else if (m_lock != 0) begin
            st = 2;
        end else if (op == 0) begin
            if (pin == PinCode) begin
                st     = 0;
                m_sess = 1;
                m_att  = 0;
            end else begin
                m_att++;
                if (m_att >= 3) begin
                    st     = 2;
                    m_lock = 1;
                    m_sess = 0;
                    m_att  = 0;
                end else begin
                    st = 1;
                end
            end
        end else if (m_sess == 0) begin
            st = 3;
        end else if (op == 1) begin
            if (amt > FaceLimit && face == 0) st = 6;
            else if (amt > m_bal) st = 4;
            else begin
                m_bal = m_bal - amt;
                st    = 0;
            end
        end else begin
            if (amt > MaxDep) st = 5;
            else if (m_bal + amt > 15) st = 7;
            else begin
                m_bal = m_bal + amt;
                st    = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got response status %0d, expected none",
                         bus.rsp_status);
            end else begin
                e = sb.pop_front();
                check("rsp_status", int'(bus.rsp_status), e.status);
                check("rsp_balance", int'(bus.rsp_balance), e.balance);
                check("locked", int'(bus.locked), e.locked);
                check("session", int'(bus.session), e.session);
            end
        end
    end

    task automatic check_idle_state(input string tag);
        check({tag, "_req_ready"}, int'(bus.req_ready), 1);
        check({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
        check({tag, "_balance"}, int'(bus.rsp_balance), m_bal);
        check({tag, "_locked"}, int'(bus.locked), 0);
        check({tag, "_session"}, int'(bus.session), 0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        #1;
        check("reset_status", int'(bus.rsp_status), 0);
        check_idle_state("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Called and returns at posedge+#1.
    task automatic do_req(input op_e op, input int pin, input int amt, input int face,
                          input int hold);
        int   n;
        int   st;
        exp_t e;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("req_ready_timeout", 0, 1);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_pin    = 4'(pin);
        bus.req_amount = 4'(amt);
        bus.face_ok    = 1'(face);
        @(posedge clk);
        model_exec(int'(op), pin, amt, face, st);
        e.status  = st;
        e.balance = m_bal;
        e.locked  = m_lock;
        e.session = m_sess;
        sb.push_back(e);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_pin    = 4'($urandom);
        bus.req_amount = 4'($urandom);
        // Accept cycle + 2: one edge after the accepting edge.
        n = 0;
        while (!bus.rsp_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rsp_latency", n, 1);
        for (int i = 0; i < hold; i++) begin
            check("hold_status", int'(bus.rsp_status), st);
            check("hold_rsp_valid", int'(bus.rsp_valid), 1);
            check("hold_req_ready", int'(bus.req_ready), 0);
            bus.req_valid = 1'($urandom);
            bus.req_op    = op_e'($urandom);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic unlock_or_reset();
`ifdef BANK_HOST_LOCK_TIMEOUT_EN
        repeat (20) @(posedge clk);
        #1;
        m_lock = 0;
        check("lock_released", int'(bus.locked), 0);
`else
        repeat (20) @(posedge clk);
        #1;
        check("lock_sticky", int'(bus.locked), 1);
        apply_reset();
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = OpPin;
        bus.req_pin    = '0;
        bus.req_amount = '0;
        bus.face_ok    = 1'b0;
        bus.rsp_ready  = 1'b0;
        @(posedge clk);
        #1;
        apply_reset();

        do_req(OpPin, 1, 0, 0, 0);
        do_req(OpWdr, 0, 12, 0, 1);
        do_req(OpWdr, 0, 12, 1, 0);
        do_req(OpWdr, 0, 3, 1, 2);
        do_req(OpDep, 0, 10, 0, 0);
        do_req(OpDep, 0, 2, 0, 0);
        do_req(OpDep, 0, 11, 0, 0);
        do_req(OpDep, 0, 2, 0, 0);
        do_req(OpDep, 0, 1, 0, 0);
        do_req(OpWdr, 0, 0, 0, 0);
        do_req(OpEnd, 0, 0, 0, 0);
        do_req(OpWdr, 0, 1, 0, 5);
        do_req(OpPin, 5, 0, 0, 0);
        do_req(OpPin, 5, 0, 0, 0);
        do_req(OpPin, 5, 0, 0, 0);
        do_req(OpPin, 1, 0, 0, 0);
        unlock_or_reset();
        do_req(OpPin, 1, 0, 0, 0);

        // Reset while a request is executing: it must be dropped.
        bus.req_valid  = 1'b1;
        bus.req_op     = OpDep;
        bus.req_amount = 4'd1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        apply_reset();
        repeat (3) @(posedge clk);
        #1;
        check_idle_state("post_abort");

        for (int k = 0; k < 300; k++) begin
            int op, pin;
            op  = int'($urandom_range(0, 3));
            pin = ($urandom_range(0, 1) == 1) ? PinCode : int'($urandom_range(0, 15));
            do_req(op_e'(op), pin, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)));
            if (m_lock != 0) unlock_or_reset();
        end

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bank_host_responder.md
BANK_HOST_RESPONDER -- requirements
Module: bank_host_responder

Interface
REQ-001 Parameter PIN_CODE, default 4'd1, account PIN compared against requests.
REQ-002 Parameter INIT_BALANCE, default 4'd14, balance in k-rupees after reset.
REQ-003 Parameter FACE_LIMIT, default 10, withdrawals above this need face_ok.
REQ-004 Parameter MAX_DEPOSIT, default 10, largest accepted deposit.
REQ-005 Parameter LOCK_CYCLES, default 16, lock duration in clk cycles when timeout compiled in.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 req_valid  input  1  ATM controller presents a request.
REQ-009 req_ready  output  1  responder accepts a request this cycle.
REQ-010 req_op  input  2  OP_PIN=0, OP_WDR=1, OP_DEP=2, OP_END=3.
REQ-011 req_pin  input  4  PIN for OP_PIN.
REQ-012 req_amount  input  4  amount in k-rupees for OP_WDR/OP_DEP.
REQ-013 face_ok  input  1  face-recognition pass, sampled with the request.
REQ-014 rsp_valid  output  1  response available.
REQ-015 rsp_ready  input  1  controller consumes the response.
REQ-016 rsp_status  output  3  status code, see REQ-022.
REQ-017 rsp_balance  output  4  balance after the request executes.
REQ-018 locked  output  1  card locked.
REQ-019 session  output  1  PIN verified, transactions allowed.

Function
REQ-020 FSM states IDLE, EXEC, RESP; req_ready=1 only in IDLE; handshake on req_valid&&req_ready latches op, pin, amount, face_ok; IDLE->EXEC.
REQ-021 EXEC evaluates the latched request, updates balance/session/attempts/lock, goes to RESP; rsp_valid=1 exactly in RESP, first asserted 2 cycles after acceptance.
REQ-022 Status codes: OK=0, BAD_PIN=1, LOCKED=2, NO_SESSION=3, INSUFF=4, LIMIT=5, FACE_FAIL=6, OVERFLOW=7.
REQ-023 OP_END: always OK; clears session; balance unchanged; attempt counter unaffected.
REQ-024 Any other op while locked: LOCKED, no state change.
REQ-025 OP_PIN match: OK, session=1, attempts=0.
REQ-026 OP_PIN mismatch: attempts+1 (2-bit); status BAD_PIN on attempts 1-2; on 3rd: locked=1, session=0, attempts=0, status LOCKED.
REQ-027 OP_WDR/OP_DEP with session=0: NO_SESSION.
REQ-028 OP_WDR checks in order: amount>FACE_LIMIT && !face_ok -> FACE_FAIL; amount>balance -> INSUFF; else balance-=amount, OK; balance never negative.
REQ-029 OP_DEP checks in order: amount>MAX_DEPOSIT -> LIMIT; 5-bit balance+amount>15 -> OVERFLOW; else balance+=amount, OK.
REQ-030 Rejected requests leave balance unchanged; amount 0 returns OK, balance unchanged.
REQ-031 RESP holds rsp_status/rsp_balance stable until rsp_ready; RESP->IDLE on rsp_valid&&rsp_ready; req_valid during EXEC/RESP ignored, not queued.
REQ-032 rsp_balance equals balance register at all times; outputs registered.

Reset
REQ-033 reset low: state IDLE, balance=INIT_BALANCE, attempts=0, locked=0, session=0, rsp_valid=0, rsp_status=OK, lock timer=0; mid-transaction reset discards the request.

Configuration
REQ-034 Macro BANK_HOST_LOCK_TIMEOUT_EN defined: lock timer counts from lock assertion, clears locked after LOCK_CYCLES cycles; undefined: locked stays 1 until reset, timer absent.

Structure
REQ-035 Package bank_host_pkg holds op enum, status enum, FSM state enum.
REQ-036 Sub-module bank_host_lock_timer (start, expire), instantiated only under BANK_HOST_LOCK_TIMEOUT_EN.

Verification
REQ-037 After reset, OP_PIN pin=1 -> OK, session=1, rsp_balance=14, rsp_valid 2 cycles after accept.
REQ-038 OP_PIN pin=5 three times -> BAD_PIN, BAD_PIN, LOCKED, locked=1; next OP_PIN pin=1 -> LOCKED.
REQ-039 Session open, OP_WDR amount=12 face_ok=0 -> FACE_FAIL, balance 14; face_ok=1 -> OK, balance 2; then amount=3 -> INSUFF, balance 2.
REQ-040 Balance 14, OP_DEP 11 -> LIMIT; OP_DEP 2 -> OVERFLOW; OP_DEP 1 -> OK, balance 15.
REQ-041 OP_END then OP_WDR 1 -> NO_SESSION; rsp_ready held low 5 cycles -> status stable, req_ready=0.
REQ-042 With BANK_HOST_LOCK_TIMEOUT_EN, lock then wait 16 cycles -> locked=0, OP_PIN pin=1 -> OK.
